// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage indices and forward-select encoding.
package pipe_pkg;

  typedef enum logic [2:0] {
    STG_F = 3'd0,
    STG_D = 3'd1,
    STG_E = 3'd2,
    STG_M = 3'd3,
    STG_W = 3'd4
  } stage_e;

  localparam int NSTAGE = 5;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

endpackage

// File: rtl/fwd_match.sv
// Compares one execute-stage source index against all producer stages and
// returns the priority forward select (youngest match wins) plus a load hit
// against producer 0.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NFWD   = 2,
  parameter int FW_W   = $clog2(NFWD + 1)
) (
  input  logic [REG_AW-1:0]      src,
  input  logic [NFWD*REG_AW-1:0] dst_reg,
  input  logic [NFWD-1:0]        dst_we,
  input  logic                   is_load0,
  output logic [FW_W-1:0]        sel,
  output logic                   load_hit
);

  logic src_nz;
  assign src_nz = (src != '0);

  // Scan oldest to youngest so the lowest matching producer index wins.
  always_comb begin
    sel = FW_W'(FWD_RF);
    for (int unsigned k = NFWD; k > 0; k--) begin
      if (src_nz && dst_we[k-1] && (dst_reg[(k-1)*REG_AW +: REG_AW] == src))
        sel = FW_W'(k);
    end
  end

  // Load in the youngest producer that this source depends on.
  always_comb begin
    load_hit = src_nz && dst_we[0] && is_load0 && (dst_reg[REG_AW-1:0] == src);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the F/D/E/M/W core: stall/flush
// vectors, operand forwarding selects and load-use interlock.
// Optional macro HAZARD_PERF_EN adds saturating stall/interlock counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int NFWD   = 2,
  parameter int FW_W   = $clog2(NFWD + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_cache_stall,
  input  logic                   d_cache_stall,
  input  logic                   alu_stallE,
  input  logic                   flush_jump_conflictE,
  input  logic                   flush_pred_failedM,
  input  logic                   flush_exceptionM,
  input  logic [NSRC*REG_AW-1:0] src_regE,
  input  logic [NFWD*REG_AW-1:0] dst_reg,
  input  logic [NFWD-1:0]        dst_we,
  input  logic [NFWD-1:0]        dst_is_load,
  output logic [NSTAGE-1:0]      stall,
  output logic [NSTAGE-1:0]      flush,
  output logic                   longest_stall,
  output logic [NSRC*FW_W-1:0]   fwd_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]            perf_cache_stall_cnt,
  output logic [31:0]            perf_alu_stall_cnt,
  output logic [31:0]            perf_lu_cnt
`endif
);

  logic            cache_st;
  logic            pend_jc;
  logic            pend_pf;
  logic            jc_eff;
  logic            pf_eff;
  logic            lu;
  logic [NSRC-1:0] load_hit;
  logic            unused_load_hi;

  // Only producer 0 can cause a load-use bubble; older load flags are unused.
  assign unused_load_hi = ^dst_is_load;

  assign cache_st      = i_cache_stall | d_cache_stall;
  assign longest_stall = cache_st | alu_stallE;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fwd_match #(
      .REG_AW (REG_AW),
      .NFWD   (NFWD),
      .FW_W   (FW_W)
    ) u_fwd_match (
      .src      (src_regE[s*REG_AW +: REG_AW]),
      .dst_reg  (dst_reg),
      .dst_we   (dst_we),
      .is_load0 (dst_is_load[0]),
      .sel      (fwd_sel[s*FW_W +: FW_W]),
      .load_hit (load_hit[s])
    );
  end

  // Effective flushes: a request (live or pending) fires once its blocking stall drops.
  always_comb begin
    jc_eff = (flush_jump_conflictE | pend_jc) & ~d_cache_stall;
    pf_eff = (flush_pred_failedM | pend_pf) & ~longest_stall;
    lu     = (|load_hit) & ~longest_stall & ~flush_exceptionM & ~pf_eff;
  end

  // Stall and flush vectors per stage.
  always_comb begin
    stall        = '0;
    flush        = '0;
    stall[STG_F] = (longest_stall | lu) & ~flush_exceptionM;
    stall[STG_D] = longest_stall | lu;
    stall[STG_E] = longest_stall | lu;
    stall[STG_M] = cache_st;
    stall[STG_W] = cache_st;
    flush[STG_D] = flush_exceptionM | flush_pred_failedM | jc_eff;
    flush[STG_E] = flush_exceptionM | pf_eff;
    flush[STG_M] = flush_exceptionM | lu;
    flush[STG_W] = flush_exceptionM;
  end

  // Pending flush latches; an exception discards both since it kills everything anyway.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_jc <= 1'b0;
      pend_pf <= 1'b0;
    end else if (flush_exceptionM) begin
      pend_jc <= 1'b0;
      pend_pf <= 1'b0;
    end else begin
      pend_jc <= (pend_jc | (flush_jump_conflictE & d_cache_stall)) & ~jc_eff;
      pend_pf <= (pend_pf | (flush_pred_failedM & longest_stall)) & ~pf_eff;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_cache_stall_cnt <= '0;
      perf_alu_stall_cnt   <= '0;
      perf_lu_cnt          <= '0;
    end else begin
      if (cache_st && (perf_cache_stall_cnt != '1))
        perf_cache_stall_cnt <= perf_cache_stall_cnt + 32'd1;
      if (alu_stallE && !cache_st && (perf_alu_stall_cnt != '1))
        perf_alu_stall_cnt <= perf_alu_stall_cnt + 32'd1;
      if (lu && (perf_lu_cnt != '1))
        perf_lu_cnt <= perf_lu_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized cycles checked against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int NSRC   = 2;
  localparam int NFWD   = 2;
  localparam int FW_W   = $clog2(NFWD + 1);

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   i_cache_stall, d_cache_stall, alu_stallE;
  logic                   flush_jump_conflictE, flush_pred_failedM, flush_exceptionM;
  logic [NSRC*REG_AW-1:0] src_regE;
  logic [NFWD*REG_AW-1:0] dst_reg;
  logic [NFWD-1:0]        dst_we, dst_is_load;
  logic [4:0]             stall, flush;
  logic                   longest_stall;
  logic [NSRC*FW_W-1:0]   fwd_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0]            perf_cache_stall_cnt, perf_alu_stall_cnt, perf_lu_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: outstanding (not yet honoured) flush requests.
  bit m_jc_outstanding, m_pf_outstanding;
  bit m_jc_fire, m_pf_fire;

  pipe_hazard_ctrl #(
    .REG_AW (REG_AW),
    .NSRC   (NSRC),
    .NFWD   (NFWD),
    .FW_W   (FW_W)
  ) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .i_cache_stall        (i_cache_stall),
    .d_cache_stall        (d_cache_stall),
    .alu_stallE           (alu_stallE),
    .flush_jump_conflictE (flush_jump_conflictE),
    .flush_pred_failedM   (flush_pred_failedM),
    .flush_exceptionM     (flush_exceptionM),
    .src_regE             (src_regE),
    .dst_reg              (dst_reg),
    .dst_we               (dst_we),
    .dst_is_load          (dst_is_load),
    .stall                (stall),
    .flush                (flush),
    .longest_stall        (longest_stall),
    .fwd_sel              (fwd_sel)
`ifdef HAZARD_PERF_EN
    ,
    .perf_cache_stall_cnt (perf_cache_stall_cnt),
    .perf_alu_stall_cnt   (perf_alu_stall_cnt),
    .perf_lu_cnt          (perf_lu_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    i_cache_stall = 0; d_cache_stall = 0; alu_stallE = 0;
    flush_jump_conflictE = 0; flush_pred_failedM = 0; flush_exceptionM = 0;
    src_regE = '0; dst_reg = '0; dst_we = '0; dst_is_load = '0;
  endtask

  // Behavioural reference: derive expected outputs from the stage rules.
  task automatic model_check(input string tag);
    int cache, lng, exc, lu, es, ef, sv, sel;
    cache = (i_cache_stall || d_cache_stall) ? 1 : 0;
    lng   = (cache != 0 || alu_stallE) ? 1 : 0;
    exc   = flush_exceptionM ? 1 : 0;
    m_jc_fire = (flush_jump_conflictE || m_jc_outstanding) && !d_cache_stall;
    m_pf_fire = (flush_pred_failedM || m_pf_outstanding) && lng == 0;
    lu = 0;
    for (int s = 0; s < NSRC; s++) begin
      sv = int'(src_regE[s*REG_AW +: REG_AW]);
      if (sv != 0 && dst_we[0] && dst_is_load[0] && int'(dst_reg[0 +: REG_AW]) == sv) lu = 1;
    end
    if (lng != 0 || exc != 0 || m_pf_fire) lu = 0;
    es = 0;
    if ((lng != 0 || lu != 0) && exc == 0) es += 1;
    if (lng != 0 || lu != 0) es += 2 + 4;
    if (cache != 0) es += 8 + 16;
    ef = 0;
    if (exc != 0 || flush_pred_failedM || m_jc_fire) ef += 2;
    if (exc != 0 || m_pf_fire) ef += 4;
    if (exc != 0 || lu != 0) ef += 8;
    if (exc != 0) ef += 16;
    chk({tag, ".stall"}, 32'(stall), 32'(es));
    chk({tag, ".flush"}, 32'(flush), 32'(ef));
    chk({tag, ".longest"}, 32'(longest_stall), 32'(lng));
    if (lu == 0) begin
      for (int s = 0; s < NSRC; s++) begin
        sv = int'(src_regE[s*REG_AW +: REG_AW]);
        sel = 0;
        for (int k = NFWD - 1; k >= 0; k--)
          if (sv != 0 && dst_we[k] && int'(dst_reg[k*REG_AW +: REG_AW]) == sv) sel = k + 1;
        chk({tag, ".fwd"}, 32'(fwd_sel[s*FW_W +: FW_W]), 32'(sel));
      end
    end
  endtask

  // Settle, check against the model, then advance one clock with the model.
  task automatic step(input string tag);
    #2;
    model_check(tag);
    @(posedge clk);
    if (!resetn || flush_exceptionM) begin
      m_jc_outstanding = 0;
      m_pf_outstanding = 0;
    end else begin
      if (m_jc_fire) m_jc_outstanding = 0;
      else if (flush_jump_conflictE && d_cache_stall) m_jc_outstanding = 1;
      if (m_pf_fire) m_pf_outstanding = 0;
      else if (flush_pred_failedM && (i_cache_stall || d_cache_stall || alu_stallE)) m_pf_outstanding = 1;
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    resetn = 0;
    m_jc_outstanding = 0;
    m_pf_outstanding = 0;
    @(posedge clk); #1;

    // Reset state with all inputs low.
    #2;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.flush", 32'(flush), 32'd0);
    chk("rst.fwd", 32'(fwd_sel), 32'd0);
    chk("rst.longest", 32'(longest_stall), 32'd0);
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;

    // Forwarding priority: src1=5 from M, src0=3 from W.
    src_regE = {5'd5, 5'd3}; dst_reg = {5'd3, 5'd5}; dst_we = 2'b11;
    #2;
    chk("fwd.dir", 32'(fwd_sel), 32'b0110);
    step("fwd");

    // Register 0 never forwarded.
    src_regE = {5'd0, 5'd0}; dst_reg = {5'd0, 5'd0}; dst_we = 2'b11;
    #2;
    chk("r0.dir", 32'(fwd_sel), 32'd0);
    step("r0");

    // Load-use: bubble, then forward from W.
    src_regE = {5'd0, 5'd7}; dst_reg = {5'd0, 5'd7}; dst_we = 2'b01; dst_is_load = 2'b01;
    #2;
    chk("lu1.stall", 32'(stall), 32'b00111);
    chk("lu1.flush", 32'(flush), 32'b01000);
    step("lu1");
    dst_reg = {5'd7, 5'd0}; dst_we = 2'b10; dst_is_load = 2'b10;
    #2;
    chk("lu2.fwd", 32'(fwd_sel[FW_W-1:0]), 32'd2);
    chk("lu2.stall", 32'(stall), 32'd0);
    step("lu2");
    clear_inputs();

    // Mispredict held off by a 3-cycle ALU stall.
    flush_pred_failedM = 1; alu_stallE = 1;
    #2;
    chk("pf.req_flushD", 32'(flush[1]), 32'd1);
    chk("pf.req_flushE", 32'(flush[2]), 32'd0);
    step("pf0");
    flush_pred_failedM = 0;
    step("pf1");
    step("pf2");
    alu_stallE = 0;
    #2;
    chk("pf.release_flushE", 32'(flush[2]), 32'd1);
    step("pf3");
    #2;
    chk("pf.after_flush", 32'(flush), 32'd0);
    step("pf4");

    // Jump conflict during D-cache stall, killed by an exception.
    flush_jump_conflictE = 1; d_cache_stall = 1;
    step("jc0");
    flush_jump_conflictE = 0; flush_exceptionM = 1;
    #2;
    chk("jc.exc_flush", 32'(flush), 32'b11110);
    chk("jc.exc_stallF", 32'(stall[0]), 32'd0);
    step("jc1");
    clear_inputs();
    #2;
    chk("jc.no_late_flushD", 32'(flush[1]), 32'd0);
    step("jc2");

    // Asynchronous reset mid-stall discards a pending mispredict.
    flush_pred_failedM = 1; alu_stallE = 1;
    step("ar0");
    flush_pred_failedM = 0;
    #2;
    resetn = 0;
    m_pf_outstanding = 0;
    m_jc_outstanding = 0;
    #2;
    resetn = 1;
    alu_stallE = 0;
    #1;
    chk("ar.no_flushE", 32'(flush[2]), 32'd0);
    @(posedge clk); #1;

    // Randomized cycles against the model.
    for (int n = 0; n < 400; n++) begin
      i_cache_stall        = ($urandom_range(0, 9) == 0);
      d_cache_stall        = ($urandom_range(0, 7) == 0);
      alu_stallE           = ($urandom_range(0, 7) == 0);
      flush_jump_conflictE = ($urandom_range(0, 5) == 0);
      flush_pred_failedM   = ($urandom_range(0, 5) == 0);
      flush_exceptionM     = ($urandom_range(0, 19) == 0);
      for (int s = 0; s < NSRC; s++) src_regE[s*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
      for (int k = 0; k < NFWD; k++) dst_reg[k*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
      dst_we      = NFWD'($urandom);
      dst_is_load = NFWD'($urandom);
      step("rnd");
    end
    clear_inputs();

`ifdef HAZARD_PERF_EN
    resetn = 0; #2; resetn = 1;
    @(posedge clk); #1;
    i_cache_stall = 1;
    repeat (10) @(posedge clk);
    #1;
    i_cache_stall = 0; alu_stallE = 1;
    repeat (4) @(posedge clk);
    #1;
    alu_stallE = 0;
    chk("perf.cache", perf_cache_stall_cnt, 32'd10);
    chk("perf.alu", perf_alu_stall_cnt, 32'd4);
    chk("perf.lu", perf_lu_cnt, 32'd0);
    resetn = 0; #2;
    chk("perf.rst_cache", perf_cache_stall_cnt, 32'd0);
    chk("perf.rst_alu", perf_alu_stall_cnt, 32'd0);
    resetn = 1;
    @(posedge clk); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and pipeline-control unit for the five-stage F/D/E/M/W core. It generates per-stage stall/flush vectors and operand-forwarding selects for NSRC execute-stage sources from NFWD producer stages. It also adds a hardware load-use interlock. Flush requests that collide with a stall are latched as pending and released on the first unstalled cycle, so no delay-slot or wrong-path instruction is lost or duplicated.

## Interface
- REG_AW, 5, register index width
- NSRC, 2, execute-stage source operands needing forwarding
- NFWD, 2, producer stages checked; index 0 = M (youngest), NFWD-1 = oldest
- FW_W, $clog2(NFWD+1), width of one forward select
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- i_cache_stall, d_cache_stall  in  1 each  cache miss in progress
- alu_stallE  in  1  multi-cycle ALU (div/mul) busy in E
- flush_jump_conflictE  in  1  jump conflict resolved in E; kills D
- flush_pred_failedM  in  1  branch mispredict resolved in M; kills D and E
- flush_exceptionM  in  1  exception taken in M; kills F..W
- src_regE  in  NSRC*REG_AW  source register indices in E
- dst_reg  in  NFWD*REG_AW  destination index per producer
- dst_we  in  NFWD  producer writes register file
- dst_is_load  in  NFWD  producer is a memory load
- stall  out  5  {W,M,E,D,F} stall, bit 0 = F
- flush  out  5  {W,M,E,D,F} flush, bit 0 = F
- longest_stall  out  1  any cache or ALU stall
- fwd_sel  out  NSRC*FW_W  per source: 0 = register file, k+1 = producer k

## Operation
- cache_st = i_cache_stall | d_cache_stall; longest_stall = cache_st | alu_stallE.
- Forwarding per source s:
  - Select the lowest k with dst_we[k], dst_reg[k]==src_regE[s] and src_regE[s]!=0.
  - Register 0 is never forwarded, for any source.
- Load-use interlock (lu):
  - lu = any source s with src!=0 that matches producer 0 with dst_we[0] & dst_is_load[0], while longest_stall==0.
  - While lu holds, fwd_sel for that source is don't-care.
  - lu stalls F, D and E and flushes M (bubble) for one cycle.
- Stall vector:
  - F: longest_stall | lu, masked to 0 when flush_exceptionM.
  - D, E: longest_stall | lu.
  - M, W: cache_st.
- Flush vector:
  - F: 0.
  - D: flush_exceptionM | flush_pred_failedM | jc_eff.
  - E: flush_exceptionM | pf_eff.
  - M: flush_exceptionM | lu.
  - W: flush_exceptionM.
- Pending registers:
  - pend_jc: set when flush_jump_conflictE & d_cache_stall.
  - pend_pf: set when flush_pred_failedM & longest_stall.
  - jc_eff = (flush_jump_conflictE | pend_jc) & ~d_cache_stall; pend_jc clears when jc_eff=1.
  - pf_eff = (flush_pred_failedM | pend_pf) & ~longest_stall; pend_pf clears when pf_eff=1.
  - flush_exceptionM clears both pending registers and overrides everything.
- Simultaneous events:
  - Exception has priority over mispredict, mispredict over jump conflict, and all three over lu.
  - lu is suppressed when flush_exceptionM or pf_eff is asserted.

## Timing
- Stall, flush and forward outputs are combinational from current inputs and pending registers; zero added latency.
- Pending registers update on rising clk; a flush request is honoured in the first cycle its blocking stall is low.
- lu lasts exactly one cycle per load: after the bubble the load is at producer index 1, so forwarding resumes from it.
- resetn low, asynchronous: pend_jc = pend_pf = 0, all perf counters 0.
  - With all inputs low, every output is 0.
  - Reset asserted mid-stall discards pending flushes.

## Configuration
- HAZARD_PERF_EN defined adds three 32-bit saturating output counters:
  - perf_cache_stall_cnt: increments each cycle cache_st.
  - perf_alu_stall_cnt: increments each cycle alu_stallE & ~cache_st.
  - perf_lu_cnt: increments each cycle lu.
- Counters reset to 0 and hold at 32'hFFFF_FFFF.
- Without the macro these ports and counters do not exist; core behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - Stage index constants STG_F=0 … STG_W=4 and NSTAGE=5.
  - Forward-select encoding constants FWD_RF=0.
- Sub-module fwd_match (one per source, generate loop): compares one src index against NFWD producers and returns the priority select plus a load hit.

## Test plan
- src_regE={5,3}, dst_reg={M:5,W:3}, dst_we=2'b11, no loads -> fwd_sel={1,2}, all stall/flush 0.
- src=0, producer M writes reg 0 -> fwd_sel=0 for that source.
- Load in M to r7, src r7 in E -> cycle 1: stall=5'b00111, flush=5'b01000; cycle 2 (load at W) -> fwd_sel=2, stall=0.
- flush_pred_failedM with alu_stallE high for 3 cycles -> flush[E]=0 during the stall, flush[D]=1 in the request cycle, flush[E]=1 in the first cycle alu_stallE=0, then pend_pf=0.
- flush_jump_conflictE with d_cache_stall for 2 cycles, then flush_exceptionM during the stall -> pend_jc cleared; flush=5'b11110, stall[F]=0; no late flush[D].
- HAZARD_PERF_EN: 10 cycles i_cache_stall, then 4 cycles alu_stallE -> cache count 10, ALU count 4; resetn pulse -> all 0.
